// File: rtl/core_pkg.sv
// Shared core definitions: data width, next-PC select codes and the fetch FSM states.
package core_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] NSEL_SEQ  = 3'b000;
   localparam logic [2:0] NSEL_J    = 3'b001;
   localparam logic [2:0] NSEL_BEQ  = 3'b010;
   localparam logic [2:0] NSEL_BGEZ = 3'b011;
   localparam logic [2:0] NSEL_BRN  = 3'b100;
   localparam logic [2:0] NSEL_JM   = 3'b101;
   localparam logic [2:0] NSEL_BALZ = 3'b110;
   localparam logic [2:0] NSEL_RSVD = 3'b111;

   typedef enum logic [1:0] {
      FS_FETCH = 2'd0,
      FS_HOLD  = 2'd1,
      FS_DROP  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/next_pc_logic.sv
// Resolves whether a control-flow instruction is taken and where it goes.
// Purely combinational so the execute-stage branch check can share it.
module next_pc_logic
   import core_pkg::*;
(
   input  logic [2:0]      i_sel,
   input  logic            i_flag_zero,
   input  logic            i_flag_neg,
   input  logic [XLEN-1:0] i_pc4,
   input  logic [XLEN-1:0] i_off,
   input  logic [25:0]     i_jidx,
   input  logic [XLEN-1:0] i_rs,
   input  logic [XLEN-1:0] i_mem,
   output logic            o_taken,
   output logic [XLEN-1:0] o_target
);

   logic [XLEN-1:0] w_branch;
   logic [XLEN-1:0] w_raw;

   assign w_branch = i_pc4 + (i_off << 2);

   always_comb begin
      o_taken = 1'b0;
      w_raw   = i_pc4;
      case (i_sel)
         NSEL_J: begin
            o_taken = 1'b1;
            w_raw   = {i_pc4[31:28], i_jidx, 2'b00};
         end
         NSEL_BEQ: begin
            o_taken = i_flag_zero;
            w_raw   = w_branch;
         end
         NSEL_BGEZ: begin
            o_taken = ~i_flag_neg;
            w_raw   = w_branch;
         end
         NSEL_BRN: begin
            o_taken = i_flag_neg;
            w_raw   = i_rs;
         end
         NSEL_JM: begin
            o_taken = 1'b1;
            w_raw   = i_mem;
         end
         NSEL_BALZ: begin
            o_taken = i_flag_zero;
            w_raw   = w_branch;
         end
         default: begin
            o_taken = 1'b0;
            w_raw   = i_pc4;
         end
      endcase
   end

   // Register and memory targets may be unaligned; fetch is always word-aligned.
   assign o_target = {w_raw[XLEN-1:2], 2'b00};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem reads, hands instructions to decode.
//   state    | meaning
//   FS_FETCH | request outstanding at r_pc, waiting for imem_ack
//   FS_HOLD  | instruction held for decode until instr_ready
//   FS_DROP  | squashed request still outstanding at r_drop_addr; data discarded
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] pc4_out,
   input  logic            redir_valid,
   input  logic [2:0]      redir_sel,
   input  logic [XLEN-1:0] redir_pc4,
   input  logic [XLEN-1:0] redir_off,
   input  logic [25:0]     redir_jidx,
   input  logic [XLEN-1:0] redir_rs,
   input  logic [XLEN-1:0] redir_mem,
   input  logic            flag_zero,
   input  logic            flag_neg
);

   fetch_state_e    r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_drop_addr;
   logic            r_instr_valid;
   logic [XLEN-1:0] r_instr_out;
   logic [XLEN-1:0] r_pc4_out;

   logic            w_taken;
   logic [XLEN-1:0] w_target;
   logic            w_redir;
   logic [XLEN-1:0] w_pc_inc;

   next_pc_logic u_next_pc (
      .i_sel       (redir_sel),
      .i_flag_zero (flag_zero),
      .i_flag_neg  (flag_neg),
      .i_pc4       (redir_pc4),
      .i_off       (redir_off),
      .i_jidx      (redir_jidx),
      .i_rs        (redir_rs),
      .i_mem       (redir_mem),
      .o_taken     (w_taken),
      .o_target    (w_target)
   );

   assign w_redir  = redir_valid & w_taken;
   assign w_pc_inc = r_pc + 32'd4;

   // Gated by reset so the first request appears right after reset releases.
   assign imem_req    = ~reset & (r_state != FS_HOLD);
   assign imem_addr   = (r_state == FS_DROP) ? r_drop_addr : r_pc;
   assign instr_valid = r_instr_valid;
   assign instr_out   = r_instr_out;
   assign pc4_out     = r_pc4_out;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= FS_FETCH;
         r_pc          <= RESET_PC;
         r_drop_addr   <= '0;
         r_instr_valid <= 1'b0;
         r_instr_out   <= '0;
         r_pc4_out     <= '0;
      end else begin
         case (r_state)
            FS_FETCH: begin
               if (w_redir) begin
                  r_pc <= w_target;
                  if (!imem_ack) begin
                     r_drop_addr <= r_pc;
                     r_state     <= FS_DROP;
                  end
               end else if (imem_ack) begin
                  r_instr_out   <= imem_rdata;
                  r_pc4_out     <= w_pc_inc;
                  r_pc          <= w_pc_inc;
                  r_instr_valid <= 1'b1;
                  r_state       <= FS_HOLD;
               end
            end
            FS_HOLD: begin
               if (w_redir) begin
                  r_pc          <= w_target;
                  r_instr_valid <= 1'b0;
                  r_state       <= FS_FETCH;
               end else if (instr_ready) begin
                  r_instr_valid <= 1'b0;
                  r_state       <= FS_FETCH;
               end
            end
            FS_DROP: begin
               if (w_redir) begin
                  r_pc <= w_target;
               end
               if (imem_ack) begin
                  r_state <= FS_FETCH;
               end
            end
            default: begin
               r_instr_valid <= 1'b0;
               r_state       <= FS_FETCH;
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-issue MIPS-subset core. Owns the program counter, issues word reads to instruction memory, and presents each fetched instruction (opcode field feeds the main control decoder) plus its PC+4 downstream under a valid/ready handshake. Accepts resolved redirects (j, beq, bgez, brn, jm, balz) from execute and squashes wrong-path fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  word-aligned read address; stable while imem_req high
- imem_ack  in  1  memory accepted request and imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr_out/pc4_out valid to decode
- instr_ready  in  1  decode accepts instruction
- instr_out  out  32  fetched instruction
- pc4_out  out  32  address of instr_out + 4 (also link value for balz)
- redir_valid  in  1  execute presents a resolved control-flow instruction
- redir_sel  in  3  next-PC select {bnj1,bnj2,bnj3}
- redir_pc4  in  32  PC+4 of the redirecting instruction
- redir_off  in  32  sign-extended imm16
- redir_jidx  in  26  jump index field
- redir_rs  in  32  register target (brn)
- redir_mem  in  32  memory-read target (jm)
- flag_zero, flag_neg  in  1 each  ALU status of redirecting instruction

Reset is asynchronous and active-high, with a single clock `clk` and reset port `reset`.

## Operation
- redir_sel encoding: 000 SEQ, 001 J, 010 BEQ, 011 BGEZ, 100 BRN, 101 JM, 110 BALZ, 111 reserved (treated as SEQ).
- Taken: J, JM always; BEQ and BALZ if flag_zero; BGEZ if !flag_neg; BRN if flag_neg; SEQ never.
- Targets: BEQ/BGEZ/BALZ = redir_pc4 + (redir_off << 2); J = {redir_pc4[31:28], redir_jidx, 2'b00}; BRN = redir_rs; JM = redir_mem. Bits [1:0] of every target forced to 0. All adds modulo 2^32.
- Not-taken or SEQ redirect: no effect on fetch.
- FSM states: FETCH (imem_req=1), HOLD (instr_valid=1), DROP (request outstanding on squashed path, imem_req=1).
- FETCH: on imem_ack, latch imem_rdata into instr_out, pc4_out <= pc+4, pc <= pc+4, go HOLD.
- HOLD: on instr_valid & instr_ready, go FETCH; else stay, outputs stable.
- Taken redirect has priority over all events: pc <= target; from HOLD go FETCH (instruction squashed); from FETCH without ack go DROP; from FETCH with ack same cycle, discard data, go FETCH; from DROP, update pc, stay DROP.
- DROP: imem_req and imem_addr held at the squashed address; on imem_ack discard data, go FETCH at pc.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, imem_req=0 during reset, instr_valid=0, instr_out=0, pc4_out=0.
- First request: imem_req=1 with imem_addr=RESET_PC in the first cycle after reset deasserts.
- Fetch latency: ack in cycle N → instr_valid=1 in cycle N+1; zero-wait memory gives one instruction every 2 cycles.
- imem_addr never changes while imem_req=1 and no ack has been seen.
- Redirect sampled on the clk edge; instr_valid falls the following cycle. A squashed instruction is never accepted, even with instr_ready=1 in the same cycle as the redirect.
- PC wrap: 32'hFFFF_FFFC + 4 = 0, no flag.
- Reset asserted mid-transaction: aborts immediately; a late ack after reset is ignored unless imem_req=1.

## Structure
- Shared package core_pkg: NSEL_* constants (3-bit), fetch state enum, XLEN=32.
- Sub-module next_pc_logic (combinational): takes sel, flags and operands; produces taken and target. Reused by the execute-stage branch check.

## Test plan
- Reset with RESET_PC=0x100, memory acks every cycle, ready=1 → addresses 0x100, 0x104, 0x108 are issued; pc4_out is 0x104, 0x108 in turn.
- instr_ready held 0 for 5 cycles → instr_out and pc4_out stay stable, no new imem_req, and one request resumes after ready.
- BEQ with redir_pc4=0x200, off=-2, zero=1, during HOLD → instruction squashed; next imem_addr=0x1F8. The same case with zero=0 → no change.
- J with jidx=0x40, pc4=0x8000_0010, while FETCH awaits a 3-cycle ack → enters DROP, ack data discarded, next imem_addr=0x8000_0100.
- JM with mem=0x3FF, acked same cycle → imem_addr=0x3FC next request, data dropped. BRN with rs=0x40, neg=1 → 0x40.
- Reset asserted while in DROP → all outputs return to reset values asynchronously, and fetch restarts at RESET_PC.
